// File: rtl/pwm_audio_out_pkg.sv
// pwm_audio_out_pkg: shared widths, FSM encoding and mid-scale helper for the audio PWM path
package pwm_audio_out_pkg;
  localparam int DW_DEF = 8;
  localparam int DEPTH_DEF = 16;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  function automatic int mid(input int dw);
    return 1 << (dw - 1);
  endfunction
endpackage

// File: rtl/pwm_audio_out_sync_fifo.sv
// sync_fifo: power-of-two sample FIFO with occupancy count and one-cycle registered read
module sync_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic wr, rd;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
    end else begin
      wptr <= wr ? wptr + 1'b1 : wptr;
      rptr <= rd ? rptr + 1'b1 : rptr;
      level <= level + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  always_ff @(posedge CLK) begin
    if (wr) mem[wptr] <= wdata;
    if (rd) rdata <= mem[rptr];
  end
endmodule

// File: rtl/pwm_audio_out.sv
// pwm_audio_out: FIFO-fed sample player rendering each tick's sample as a 2^DW-cycle PWM period
module pwm_audio_out
  import pwm_audio_out_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = $clog2(DEPTH),
  parameter int PREFILL = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          SMP_TICK,
  input  logic [DW-1:0] DIN,
  input  logic          DIN_VALID,
  output logic          DIN_READY,
  output logic          PWM_OUT,
  output logic          UNDERRUN,
  output logic [AW:0]   LEVEL
);
  localparam logic [DW-1:0] MID = DW'(mid(DW));
  state_t state, state_nx;
  logic full, empty, push, pop, und, pop_d;
  logic [DW-1:0] rdata, cur, duty, pcnt;
  assign DIN_READY = RST && !full;
  assign push = DIN_VALID && DIN_READY;
  sync_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .CLK(CLK), .RST(RST), .push(push), .pop(pop), .wdata(DIN),
    .rdata(rdata), .level(LEVEL), .full(full), .empty(empty)
  );
  always_comb begin
    pop = state == ST_RUN && SMP_TICK && !empty;
    und = state == ST_RUN && SMP_TICK && empty;
    state_nx = state == ST_IDLE ? (LEVEL >= (AW+1)'(PREFILL) ? ST_RUN : ST_IDLE)
                                : (und ? ST_IDLE : ST_RUN);
  end
  always_ff @(posedge CLK) begin
    if (!RST) state <= ST_IDLE;
    else state <= state_nx;
  end
  // the popped word lands in rdata one cycle after the tick; an underrun overrides it
  always_ff @(posedge CLK) begin
    if (!RST) begin
      pop_d <= 1'b0;
      UNDERRUN <= 1'b0;
      cur <= MID;
      duty <= MID;
      pcnt <= '0;
      PWM_OUT <= 1'b0;
    end else begin
      pop_d <= pop;
      UNDERRUN <= und;
      cur <= und ? MID : (pop_d ? rdata : cur);
      duty <= pcnt == '1 ? cur : duty;
      pcnt <= pcnt + 1'b1;
      PWM_OUT <= pcnt < duty;
    end
  end
endmodule

// File: tb/tb_pwm_audio_out.sv
// tb_pwm_audio_out: queue-based reference model plus directed and random scenarios for pwm_audio_out
module tb_pwm_audio_out;
  localparam int MID = 128;
  logic CLK = 0, RST = 0, SMP_TICK = 0, DIN_VALID = 0;
  logic [7:0] DIN = 0;
  logic DIN_READY, PWM_OUT, UNDERRUN;
  logic [4:0] LEVEL;
  int checks = 0, failures = 0;

  always #5 CLK = ~CLK;

  pwm_audio_out #(.DW(8), .DEPTH(16), .AW(4), .PREFILL(4)) dut (
    .CLK(CLK), .RST(RST), .SMP_TICK(SMP_TICK), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DIN_READY(DIN_READY), .PWM_OUT(PWM_OUT), .UNDERRUN(UNDERRUN), .LEVEL(LEVEL)
  );

  // reference: queue of samples, playing flag, sample awaiting delivery, period position
  byte unsigned q[$];
  bit m_run, m_und, m_pwm, m_pend, t_pop, t_und;
  int m_cur, m_duty, m_pcnt, m_pendv, lvl, nxt_cur;
  always @(posedge CLK) begin
    if (!RST) begin
      q.delete();
      m_run = 0; m_und = 0; m_pwm = 0; m_pend = 0;
      m_cur = MID; m_duty = MID; m_pcnt = 0;
    end else begin
      lvl = q.size();
      t_pop = m_run && SMP_TICK && lvl > 0;
      t_und = m_run && SMP_TICK && lvl == 0;
      m_pwm = m_pcnt < m_duty;
      if (m_pcnt == 255) m_duty = m_cur;
      m_pcnt = (m_pcnt + 1) % 256;
      nxt_cur = t_und ? MID : (m_pend ? m_pendv : m_cur);
      m_pend = t_pop;
      if (t_pop) m_pendv = q.pop_front();
      if (DIN_VALID && lvl < 16) q.push_back(DIN);
      m_cur = nxt_cur;
      m_run = m_run ? !t_und : lvl >= 4;
      m_und = t_und;
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic t);
    DIN_VALID = v; DIN = d; SMP_TICK = t;
    @(negedge CLK);
  endtask

  task automatic to_wrap();
    do step(0, 0, 0); while (m_pcnt != 0);
  endtask

  logic [7:0] vals [4];

  task automatic test_reset();
    int hi, us;
    RST = 0;
    repeat (3) step(0, 0, 0);
    checks++; if (LEVEL !== 5'd0) begin failures++; $display("FAIL reset_level got %0d want 0", LEVEL); end
    checks++; if (PWM_OUT !== 1'b0) begin failures++; $display("FAIL reset_pwm got %b want 0", PWM_OUT); end
    checks++; if (UNDERRUN !== 1'b0) begin failures++; $display("FAIL reset_underrun got %b want 0", UNDERRUN); end
    checks++; if (DIN_READY !== 1'b0) begin failures++; $display("FAIL reset_ready got %b want 0", DIN_READY); end
    RST = 1; #1;
    checks++; if (PWM_OUT !== 1'b0) begin failures++; $display("FAIL release_pwm got %b want 0", PWM_OUT); end
    checks++; if (DIN_READY !== 1'b1) begin failures++; $display("FAIL release_ready got %b want 1", DIN_READY); end
    hi = 0; us = 0;
    for (int i = 0; i < 256; i++) begin
      step(0, 0, 0);
      hi += int'(PWM_OUT); us += int'(UNDERRUN);
    end
    checks++; if (hi != MID) begin failures++; $display("FAIL release_duty got %0d want %0d", hi, MID); end
    checks++; if (us != 0) begin failures++; $display("FAIL release_underrun got %0d want 0", us); end
    checks++; if (LEVEL !== 5'd0) begin failures++; $display("FAIL release_level got %0d want 0", LEVEL); end
  endtask

  task automatic test_prefill();
    vals[0] = 8'h40; vals[1] = 8'h00; vals[2] = 8'hFF; vals[3] = 8'($urandom_range(1, 254));
    for (int i = 0; i < 3; i++) step(1, vals[i], 0);
    step(0, 0, 1);
    checks++; if (UNDERRUN !== 1'b0) begin failures++; $display("FAIL idle_tick_underrun got %b want 0", UNDERRUN); end
    step(0, 0, 0);
    checks++; if (LEVEL !== 5'd3) begin failures++; $display("FAIL idle_tick_level got %0d want 3", LEVEL); end
    step(1, vals[3], 0);
    checks++; if (LEVEL !== 5'd4) begin failures++; $display("FAIL prefill_level got %0d want 4", LEVEL); end
    step(0, 0, 0);
  endtask

  task automatic test_duty();
    int hi;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1);
      checks++; if (LEVEL !== 5'(3 - i)) begin failures++; $display("FAIL pop_level[%0d] got %0d want %0d", i, LEVEL, 3 - i); end
      step(0, 0, 0);
      to_wrap();
      hi = 0;
      for (int k = 0; k < 256; k++) begin
        step(0, 0, 0);
        hi += int'(PWM_OUT);
      end
      checks++; if (hi != int'(vals[i])) begin failures++; $display("FAIL duty[%0d] got %0d want %0d", i, hi, vals[i]); end
    end
  endtask

  task automatic test_underrun();
    int hi;
    step(1, 8'($urandom), 1);
    checks++; if (UNDERRUN !== 1'b1) begin failures++; $display("FAIL underrun_pulse got %b want 1", UNDERRUN); end
    checks++; if (LEVEL !== 5'd1) begin failures++; $display("FAIL underrun_level got %0d want 1", LEVEL); end
    step(0, 0, 0);
    checks++; if (UNDERRUN !== 1'b0) begin failures++; $display("FAIL underrun_width got %b want 0", UNDERRUN); end
    to_wrap();
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      step(0, 0, (k % 64) == 3);
      hi += int'(PWM_OUT);
      checks++; if (UNDERRUN !== 1'b0) begin failures++; $display("FAIL idle_no_underrun[%0d] got %b want 0", k, UNDERRUN); end
    end
    checks++; if (hi != MID) begin failures++; $display("FAIL underrun_mid got %0d want %0d", hi, MID); end
    checks++; if (LEVEL !== 5'd1) begin failures++; $display("FAIL idle_hold_level got %0d want 1", LEVEL); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 20; i++) step(1, 8'($urandom), 0);
    checks++; if (DIN_READY !== 1'b0) begin failures++; $display("FAIL full_ready got %b want 0", DIN_READY); end
    checks++; if (LEVEL !== 5'd16) begin failures++; $display("FAIL full_level got %0d want 16", LEVEL); end
    step(1, 8'hAA, 1);
    checks++; if (LEVEL !== 5'd15) begin failures++; $display("FAIL no_writethrough got %0d want 15", LEVEL); end
    checks++; if (DIN_READY !== 1'b1) begin failures++; $display("FAIL unfull_ready got %b want 1", DIN_READY); end
    step(0, 0, 0);
  endtask

  task automatic test_reset_mid();
    int hi;
    for (int i = 0; i < 5; i++) begin step(0, 0, 1); step(0, 0, 0); end
    checks++; if (LEVEL !== 5'd10) begin failures++; $display("FAIL drain_level got %0d want 10", LEVEL); end
    while (m_pcnt != 100) step(0, 0, 0);
    RST = 0;
    step(1, 8'h55, 1);
    checks++; if (LEVEL !== 5'd0) begin failures++; $display("FAIL midrst_level got %0d want 0", LEVEL); end
    checks++; if (PWM_OUT !== 1'b0) begin failures++; $display("FAIL midrst_pwm got %b want 0", PWM_OUT); end
    checks++; if (DIN_READY !== 1'b0) begin failures++; $display("FAIL midrst_ready got %b want 0", DIN_READY); end
    RST = 1;
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      step(0, 0, 1);
      hi += int'(PWM_OUT);
    end
    checks++; if (hi != MID) begin failures++; $display("FAIL midrst_duty got %0d want %0d", hi, MID); end
    checks++; if (LEVEL !== 5'd0) begin failures++; $display("FAIL midrst_idle_level got %0d want 0", LEVEL); end
  endtask

  task automatic test_random();
    int vp, tp;
    logic exp_rdy;
    for (int i = 0; i < 6000; i++) begin
      vp = i < 2000 ? 60 : (i < 4000 ? 5 : 50);
      tp = i < 4000 ? 2 : 45;
      step($urandom_range(0, 99) < vp, 8'($urandom), $urandom_range(0, 99) < tp);
      exp_rdy = RST && q.size() != 16;
      checks++;
      if ({LEVEL, PWM_OUT, UNDERRUN, DIN_READY} !== {5'(q.size()), m_pwm, m_und, exp_rdy}) begin
        failures++;
        $display("FAIL random[%0d] got lvl=%0d pwm=%b und=%b rdy=%b want lvl=%0d pwm=%b und=%b rdy=%b",
                 i, LEVEL, PWM_OUT, UNDERRUN, DIN_READY, q.size(), m_pwm, m_und, exp_rdy);
      end
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_prefill();
    test_duty();
    test_underrun();
    test_full();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
